// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing control.
package pipe_pkg;

   localparam int unsigned REG_AW = 5;

   localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
   localparam logic [1:0] PC_SEL_BR     = 2'b01;
   localparam logic [1:0] PC_SEL_REPLAY = 2'b10;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } hz_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: flags an ID operand that reads the register an EX load writes.
// Purely combinational so a forwarding unit can reuse it.
module hazard_detect #(
   parameter int unsigned REG_AW = pipe_pkg::REG_AW
) (
   input  logic [REG_AW-1:0] id_rs1_i,
   input  logic [REG_AW-1:0] id_rs2_i,
   input  logic              id_rs1_used_i,
   input  logic              id_rs2_used_i,
   input  logic              ex_mem_read_i,
   input  logic [REG_AW-1:0] ex_rd_i,
   output logic              lu_o
);

   logic rs1_hit;
   logic rs2_hit;

   // x0 is hardwired, so a load to it never creates a dependency.
   always_comb begin
      rs1_hit = id_rs1_used_i && (id_rs1_i == ex_rd_i);
      rs2_hit = id_rs2_used_i && (id_rs2_i == ex_rd_i);
      lu_o    = ex_mem_read_i && (ex_rd_i != '0) && (rs1_hit || rs2_hit);
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: load-use replay,
// taken-branch flush and halt/drain/resume. Optional perf counters are enabled
// by defining HAZ_PERF_CNT_EN.
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int unsigned REG_AW       = pipe_pkg::REG_AW,
   parameter int unsigned DRAIN_CYCLES = 3
`ifdef HAZ_PERF_CNT_EN
   ,
   parameter int unsigned CNT_W        = 32
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_rs1_used,
   input  logic              id_rs2_used,
   input  logic              id_halt,
   input  logic              ex_mem_read,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_br_taken,
   input  logic              resume,
   output logic              pc_en,
   output logic [1:0]        pc_sel,
   output logic              if_id_en,
   output logic              id_ex_en,
`ifdef HAZ_PERF_CNT_EN
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt,
`endif
   output logic              halted
);

   // Counter loads DRAIN_CYCLES-1 so exactly DRAIN_CYCLES cycles are spent in DRAIN.
   localparam logic [1:0] CntInit = 2'(DRAIN_CYCLES - 1);

   hz_state_t  state_q, state_d;
   logic [1:0] cnt_q, cnt_d;
   logic       lu;

   hazard_detect #(
      .REG_AW (REG_AW)
   ) u_hazard_detect (
      .id_rs1_i      (id_rs1),
      .id_rs2_i      (id_rs2),
      .id_rs1_used_i (id_rs1_used),
      .id_rs2_used_i (id_rs2_used),
      .ex_mem_read_i (ex_mem_read),
      .ex_rd_i       (ex_rd),
      .lu_o          (lu)
   );

   // State and drain counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RUN;
         cnt_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state: branch beats load-use beats halt; a branch in DRAIN aborts the halt.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         RUN: begin
            if (!ex_br_taken && !lu && id_halt) begin
               state_d = DRAIN;
               cnt_d   = CntInit;
            end
         end
         DRAIN: begin
            if (ex_br_taken) begin
               state_d = RUN;
               cnt_d   = 2'd0;
            end else if (cnt_q == 2'd0) begin
               state_d = HALTED;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         HALTED: begin
            if (resume) begin
               state_d = RUN;
            end
         end
         default: begin
            state_d = RUN;
            cnt_d   = 2'd0;
         end
      endcase
   end

   // Outputs: stage enables and PC control, combinational from state and inputs.
   always_comb begin
      pc_en    = 1'b1;
      pc_sel   = PC_SEL_SEQ;
      if_id_en = 1'b1;
      id_ex_en = 1'b1;
      halted   = 1'b0;
      unique case (state_q)
         RUN: begin
            if (ex_br_taken) begin
               pc_sel   = PC_SEL_BR;
               if_id_en = 1'b0;
               id_ex_en = 1'b0;
            end else if (lu) begin
               // Drop the ID instruction and refetch it from the IF/ID pc.
               pc_sel   = PC_SEL_REPLAY;
               if_id_en = 1'b0;
               id_ex_en = 1'b0;
            end else if (id_halt) begin
               pc_en    = 1'b0;
               if_id_en = 1'b0;
            end
         end
         DRAIN: begin
            if (ex_br_taken) begin
               pc_sel   = PC_SEL_BR;
               if_id_en = 1'b0;
               id_ex_en = 1'b0;
            end else begin
               pc_en    = 1'b0;
               if_id_en = 1'b0;
            end
         end
         HALTED: begin
            pc_en    = 1'b0;
            if_id_en = 1'b0;
            id_ex_en = 1'b0;
            halted   = 1'b1;
         end
         default: ;
      endcase
   end

`ifdef HAZ_PERF_CNT_EN
   logic [CNT_W-1:0] stall_q, stall_d;
   logic [CNT_W-1:0] flush_q, flush_d;
   logic             stall_inc;
   logic             flush_inc;

   // Saturating event counters for replays and redirects.
   always_comb begin
      stall_inc = (state_q == RUN) && lu && !ex_br_taken;
      flush_inc = ((state_q == RUN) || (state_q == DRAIN)) && ex_br_taken;
      stall_d   = stall_q;
      flush_d   = flush_q;
      if (stall_inc && (stall_q != '1)) stall_d = stall_q + 1'b1;
      if (flush_inc && (flush_q != '1)) flush_d = flush_q + 1'b1;
   end

   // Perf counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         stall_q <= stall_d;
         flush_q <= flush_d;
      end
   end

   assign stall_cnt = stall_q;
   assign flush_cnt = flush_q;
`endif

endmodule
